// File: rtl/mac_sequencer.sv
// mac_sequencer: operand-side driver for one MAC lane.
// Fetches one A row and one B column from synchronous-read operand RAMs.
// Streams the element pairs into the MAC, then captures total/err.
// The captured dot-product is offered on a valid/ready result port.
module mac_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 2 * DATA_WIDTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   len,
    input  logic [ADDR_WIDTH-1:0]  a_base,
    input  logic [ADDR_WIDTH-1:0]  b_base,
    input  logic [ADDR_WIDTH-1:0]  b_stride,
    output logic                   busy,
    output logic                   a_rd_en,
    output logic [ADDR_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0]  a_rd_data,
    output logic                   b_rd_en,
    output logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0]  b_rd_data,
    output logic                   mac_clr,
    output logic                   mac_run,
    output logic [DATA_WIDTH-1:0]  mac_in1,
    output logic [DATA_WIDTH-1:0]  mac_in2,
    input  logic [ACCUM_WIDTH-1:0] mac_total,
    input  logic                   mac_err,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACCUM_WIDTH-1:0] res_data,
    output logic                   res_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;      // index j of the pair being accumulated
    logic [ADDR_WIDTH-1:0]  r_a_ptr;    // address of the next A read
    logic [ADDR_WIDTH-1:0]  r_b_ptr;    // address of the next B read
    logic [ADDR_WIDTH-1:0]  r_b_stride;
    logic [ACCUM_WIDTH-1:0] r_res_data;
    logic                   r_res_err;
    logic                   w_last;     // current STREAM cycle carries the final pair
    logic                   w_issue;    // a read pair is issued this cycle

    // r_cnt never exceeds len-1, so a maximum-length command cannot wrap it.
    assign w_last  = (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_issue = ((r_state == S_CLEAR) && (r_len != '0)) ||
                     ((r_state == S_STREAM) && !w_last);

    assign res_data = r_res_data;
    assign res_err  = r_res_err;

    // State register, command latch, address walkers and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_a_ptr    <= '0;
            r_b_ptr    <= '0;
            r_b_stride <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && start) begin
                r_len      <= len;
                r_a_ptr    <= a_base;
                r_b_ptr    <= b_base;
                r_b_stride <= b_stride;
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if ((r_state == S_STREAM) && !w_last) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end
            // B column walk by repeated addition; both pointers wrap naturally.
            if (w_issue) begin
                r_a_ptr <= r_a_ptr + ADDR_WIDTH'(1);
                r_b_ptr <= r_b_ptr + r_b_stride;
            end
            if (r_state == S_DRAIN) begin
                r_res_data <= mac_total;
                r_res_err  <= mac_err;
            end
        end
    end

    // Next-state decode and per-state drive of the memory and MAC interfaces.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        a_rd_en      = w_issue;
        b_rd_en      = w_issue;
        a_addr       = w_issue ? r_a_ptr : '0;
        b_addr       = w_issue ? r_b_ptr : '0;
        mac_clr      = 1'b0;
        mac_run      = 1'b0;
        mac_in1      = '0;
        mac_in2      = '0;
        res_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clr      = 1'b1;
                w_state_next = (r_len != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                mac_run = 1'b1;
                mac_in1 = a_rd_data;
                mac_in2 = b_rd_data;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
